// File: rtl/rx_pkg.sv
// Shared types and constants for the UART receive path.
package rx_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  // Line defaults, shared with the byte receiver.
  localparam int unsigned CLK_HZ         = 300_000_000;
  localparam int unsigned BAUD           = 115_200;
  localparam int unsigned BITS_PER_FRAME = 10;

  // Idle time of three byte frames. Scaled by 100 to stay within 32 bits.
  localparam int unsigned RX_IDLE_CYCLES =
      (3 * BITS_PER_FRAME * (CLK_HZ / 100)) / (BAUD / 100);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fallthrough read and extra-MSB pointers.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [WIDTH-1:0]      data_i,
  input  logic                  pop_i,
  output logic [WIDTH-1:0]      data_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_q [Depth];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                do_push, do_pop;

  // Status, handshake qualification and pointer advance.
  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
               (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_o  = wr_ptr_q - rd_ptr_q;
    data_o   = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
  end

  // Pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; not reset. On full+pop+push the write slot is the one being read out.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/rx_word_fifo.sv
// Packs received UART bytes MSB-first into 32-bit words and buffers them.
// Optional partial-word idle timeout: define RX_TIMEOUT_EN.
module rx_word_fifo
  import rx_pkg::*;
#(
  parameter int unsigned              DEPTH_LOG2     = 4,
  parameter int unsigned              TIMEOUT_WIDTH  = 17,
  parameter logic [TIMEOUT_WIDTH-1:0] TIMEOUT_CYCLES = TIMEOUT_WIDTH'(RX_IDLE_CYCLES)
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic [31:0]           out_word,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic [1:0]            byte_idx,
  output logic                  overflow,
  input  logic                  clr_ovf,
  input  logic                  abort
);

  localparam logic [1:0] LastIdx = 2'(BYTES_PER_WORD - 1);

  if (DEPTH_LOG2 < 1) begin : g_depth_chk
    $error("rx_word_fifo: DEPTH_LOG2 must be at least 1");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_chk
    $error("rx_word_fifo: TIMEOUT_CYCLES must be at least 2");
  end

  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] acc_q, acc_d;
  logic        ovf_q, ovf_d;
  logic        push, pop, drop, timeout_fire;
  logic        fifo_empty, fifo_full;
  word_t       push_word;

  // Byte assembler: abort beats a strobe, a strobe beats the timeout.
  always_comb begin
    byte_idx_d = byte_idx_q;
    acc_d      = acc_q;
    push       = 1'b0;
    push_word  = {acc_q, in_data};
    if (abort) begin
      byte_idx_d = 2'd0;
    end else if (in_valid) begin
      if (byte_idx_q == LastIdx) begin
        push       = 1'b1;
        byte_idx_d = 2'd0;
      end else begin
        acc_d      = {acc_q[15:0], in_data};
        byte_idx_d = byte_idx_q + 2'd1;
      end
    end else if (timeout_fire) begin
      byte_idx_d = 2'd0;
    end
  end

  // Drop detection and sticky overflow; a simultaneous drop outranks the clear.
  always_comb begin
    pop   = !fifo_empty && out_ready;
    drop  = push && fifo_full && !pop;
    ovf_d = (ovf_q && !clr_ovf) || drop;
  end

  // Assembler and overflow registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      byte_idx_q <= 2'd0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef RX_TIMEOUT_EN
  logic [TIMEOUT_WIDTH-1:0] idle_cnt_q, idle_cnt_d;

  // Idle counter for a partial word; firing resynchronises the word boundary.
  always_comb begin
    idle_cnt_d   = idle_cnt_q;
    timeout_fire = 1'b0;
    if (abort || in_valid || (byte_idx_q == 2'd0)) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == TIMEOUT_CYCLES - 1'b1) begin
      idle_cnt_d   = '0;
      timeout_fire = 1'b1;
    end else begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  // Idle counter register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  sync_fifo #(
    .WIDTH      (32),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RSTN),
    .push_i  (push),
    .data_i  (push_word),
    .pop_i   (pop),
    .data_o  (out_word),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (level)
  );

  assign out_valid = !fifo_empty;
  assign byte_idx  = byte_idx_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_rx_word_fifo.sv
// Directed self-checking bench for rx_word_fifo (DEPTH_LOG2=4).
module tb_rx_word_fifo;

`ifdef RX_TIMEOUT_EN
  localparam logic [16:0] TbTimeout = 17'd100;
`else
  localparam logic [16:0] TbTimeout = 17'd78125;
`endif

  logic        CLK, RSTN;
  logic [7:0]  in_data;
  logic        in_valid, out_ready, clr_ovf, abort;
  logic [31:0] out_word;
  logic        out_valid, overflow;
  logic [4:0]  level;
  logic [1:0]  byte_idx;

  int n_vec = 0;
  int n_err = 0;

  rx_word_fifo #(
    .DEPTH_LOG2     (4),
    .TIMEOUT_WIDTH  (17),
    .TIMEOUT_CYCLES (TbTimeout)
  ) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level),
    .byte_idx  (byte_idx),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf),
    .abort     (abort)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the strobe dropped.
  task automatic send_byte(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  function automatic logic [31:0] tw(input int k);
    return {8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k), 8'(8'h40 + k)};
  endfunction

  initial begin
    logic [31:0] x;
    RSTN = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    out_ready = 1'b0; clr_ovf = 1'b0; abort = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_level",     32'(level),     32'd0);
    check("rst_byte_idx",  32'(byte_idx),  32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    RSTN = 1'b1;
    @(negedge CLK);

    // Basic packing, MSB first, one-cycle latency, then pop.
    out_ready = 1'b1;
    send_byte(8'h12);
    send_byte(8'h34);
    check("basic_idx2", 32'(byte_idx), 32'd2);
    send_byte(8'h56);
    send_byte(8'h78);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_word",  out_word,       32'h12345678);
    check("basic_level", 32'(level),     32'd1);
    @(negedge CLK);
    check("basic_popped_level", 32'(level),     32'd0);
    check("basic_popped_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Fill to 16, then the 17th word is dropped.
    for (int k = 1; k <= 16; k++) send_word(tw(k));
    check("fill_level16", 32'(level),    32'd16);
    check("fill_no_ovf",  32'(overflow), 32'd0);
    send_word(tw(17));
    check("ovf_level16", 32'(level),    32'd16);
    check("ovf_set",     32'(overflow), 32'd1);
    check("ovf_head",    out_word,      tw(1));

    // Clear coinciding with another drop keeps overflow set.
    x = tw(18);
    send_byte(x[31:24]); send_byte(x[23:16]); send_byte(x[15:8]);
    clr_ovf = 1'b1;
    send_byte(x[7:0]);
    clr_ovf = 1'b0;
    check("clr_with_drop", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    @(negedge CLK);
    clr_ovf = 1'b0;
    check("clr_alone", 32'(overflow), 32'd0);

    // Full FIFO: push and pop in the same cycle.
    x = 32'hF00DCAFE;
    send_byte(x[31:24]); send_byte(x[23:16]); send_byte(x[15:8]);
    check("fullpop_head", out_word, tw(1));
    out_ready = 1'b1;
    send_byte(x[7:0]);
    out_ready = 1'b0;
    check("fullpop_no_ovf", 32'(overflow), 32'd0);
    check("fullpop_level",  32'(level),    32'd16);

    // Drain: words 2..16, then the late word.
    out_ready = 1'b1;
    for (int k = 2; k <= 16; k++) begin
      check($sformatf("drain_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("drain_word%0d", k),  out_word,       tw(k));
      @(negedge CLK);
    end
    check("drain_last", out_word, x);
    @(negedge CLK);
    out_ready = 1'b0;
    check("drain_empty", 32'(out_valid), 32'd0);
    check("drain_level", 32'(level),     32'd0);

    // Abort, including abort together with a fourth byte.
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    check("abort_pre_idx", 32'(byte_idx), 32'd3);
    abort = 1'b1;
    send_byte(8'hDD);
    abort = 1'b0;
    check("abort_idx",   32'(byte_idx), 32'd0);
    check("abort_level", 32'(level),    32'd0);
    send_word(32'h01020304);
    check("abort_word_level", 32'(level), 32'd1);
    check("abort_word",       out_word,   32'h01020304);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    check("abort_drained", 32'(level), 32'd0);

`ifdef RX_TIMEOUT_EN
    // 100 idle cycles: partial word discarded.
    send_byte(8'h11); send_byte(8'h22);
    repeat (100) @(negedge CLK);
    check("to100_idx", 32'(byte_idx), 32'd0);
    send_word(32'hA1A2A3A4);
    check("to100_word", out_word, 32'hA1A2A3A4);
    out_ready = 1'b1; @(negedge CLK); out_ready = 1'b0;
    // 99 idle cycles: partial word survives.
    send_byte(8'h11); send_byte(8'h22);
    repeat (99) @(negedge CLK);
    check("to99_idx", 32'(byte_idx), 32'd2);
    send_word(32'hA1A2A3A4);
    check("to99_word", out_word, 32'h1122A1A2);
    check("to99_tail", 32'(byte_idx), 32'd2);
`else
    // Without the timeout a partial word waits indefinitely.
    send_byte(8'h11); send_byte(8'h22);
    repeat (150) @(negedge CLK);
    check("persist_idx", 32'(byte_idx), 32'd2);
    send_word(32'hA1A2A3A4);
    check("persist_word", out_word, 32'h1122A1A2);
    check("persist_tail", 32'(byte_idx), 32'd2);
`endif
    out_ready = 1'b1; @(negedge CLK); out_ready = 1'b0;
    abort = 1'b1; @(negedge CLK); abort = 1'b0;

    // Reset in the middle of a transfer.
    send_word(tw(5));
    send_byte(8'h99); send_byte(8'h98);
    #2 RSTN = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_level", 32'(level),     32'd0);
    check("midrst_idx",   32'(byte_idx),  32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    @(negedge CLK);
    send_word(32'hCAFEBABE);
    check("postrst_word", out_word, 32'hCAFEBABE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
